// File: rtl/simax_pkg.sv
// Shared encodings for the systolic-array slice.
// ctrl_state_e  : controller global_state (shared with fsm_controller)
// drain_state_e : result-drain FSM states
package simax_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_X = 2'd1,
    S_MAC    = 2'd2,
    S_STORE  = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    D_IDLE    = 2'd0,
    D_CAPTURE = 2'd1,
    D_FLUSH   = 2'd2
  } drain_state_e;

endpackage

// File: rtl/systolic_result_drain_if.sv
// Result stream from the drain block to the write-back path.
// out_data    : buffered accumulator row (column 0 in LSBs)
// out_row_idx : row index of out_data
// out_valid   : head row present
// out_ready   : downstream accepts
// out_last    : head is the final row of a pass
// master = drain side (producer), slave = write-back side (consumer).
interface systolic_result_drain_if #(
  parameter int COLS  = 4,
  parameter int ACC_W = 32,
  parameter int ROWS  = 4
);
  localparam int IDX_W = $clog2(ROWS);

  logic [COLS*ACC_W-1:0] out_data;
  logic [IDX_W-1:0]      out_row_idx;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output out_data, out_row_idx, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row_idx, out_valid, out_last,
    output out_ready
  );
endinterface

// File: rtl/systolic_result_drain_fifo.sv
// sync_row_fifo: single-clock FIFO, head visible on rdata without a read cycle.
// clk, rst_n (sync, active-low), push/wdata, pop, rdata (head), full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
module sync_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[PW-1] != rd_ptr_r[PW-1]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: captures one accumulator row per cycle while the
// controller is in S_STORE, buffers rows, streams them out valid/ready.
// clk, rst_n (sync, active-low)
// global_state, cycle : controller state and per-state cycle count
// acc_row_in          : bottom-edge accumulator row from the PE array
// res                 : result stream (master modport)
// busy                : drain FSM active
// drain_done          : one-cycle pulse when a pass is captured and emitted
// overflow            : sticky, a row was dropped (cleared on S_LOAD_X)
module systolic_result_drain
  import simax_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CYCLE_W    = 5,
  parameter int ACC_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             global_state,
  input  logic [CYCLE_W-1:0]     cycle,
  input  logic [COLS*ACC_W-1:0]  acc_row_in,
  systolic_result_drain_if.master res,
  output logic                   busy,
  output logic                   drain_done,
  output logic                   overflow
);
  localparam int IDX_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(ROWS + 1);
  localparam int ROW_W = COLS * ACC_W;
  localparam int ENT_W = ROW_W + IDX_W;

  drain_state_e     state_r;
  drain_state_e     state_nxt_s;
  logic [CNT_W-1:0] rows_cap_r;
  logic             overflow_r;
  logic             cap_s;
  logic             pop_s;
  logic             drop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [ENT_W-1:0] head_s;
  logic             busy_s;
  logic             drain_done_s;

  assign cap_s  = (global_state == S_STORE) && (cycle < CYCLE_W'(ROWS)) &&
                  (rows_cap_r < CNT_W'(ROWS));
  assign pop_s  = !fifo_empty_s && res.out_ready;
  // Full with no same-cycle pop: row is lost but still counted as captured.
  assign drop_s = cap_s && fifo_full_s && !pop_s;

  sync_row_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_s),
    .wdata ({acc_row_in, cycle[IDX_W-1:0]}),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign res.out_data    = head_s[ENT_W-1:IDX_W];
  assign res.out_row_idx = head_s[IDX_W-1:0];
  assign res.out_valid   = !fifo_empty_s;
  assign res.out_last    = !fifo_empty_s && (head_s[IDX_W-1:0] == IDX_W'(ROWS - 1));

  // Rows captured this pass; a new pass starts at S_LOAD_X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_cap_r <= '0;
    end else if (global_state == S_LOAD_X) begin
      rows_cap_r <= '0;
    end else if (cap_s) begin
      rows_cap_r <= rows_cap_r + CNT_W'(1);
    end
  end

  // Sticky drop flag, cleared at the start of a new pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (global_state == S_LOAD_X) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= D_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Drain FSM next state; leaving S_STORE early (incl. to S_IDLE) ends capture.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      D_IDLE: begin
        if (cap_s) state_nxt_s = D_CAPTURE;
        else       state_nxt_s = D_IDLE;
      end
      D_CAPTURE: begin
        if ((rows_cap_r == CNT_W'(ROWS)) || (global_state != S_STORE))
          state_nxt_s = D_FLUSH;
        else
          state_nxt_s = D_CAPTURE;
      end
      D_FLUSH: begin
        if (cap_s)             state_nxt_s = D_CAPTURE;
        else if (fifo_empty_s) state_nxt_s = D_IDLE;
        else                   state_nxt_s = D_FLUSH;
      end
      default: state_nxt_s = D_IDLE;
    endcase
  end

  // Drain FSM outputs; drain_done marks the FLUSH->IDLE cycle only.
  always_comb begin
    busy_s       = 1'b0;
    drain_done_s = 1'b0;
    case (state_r)
      D_IDLE: begin
        busy_s       = 1'b0;
        drain_done_s = 1'b0;
      end
      D_CAPTURE: begin
        busy_s       = 1'b1;
        drain_done_s = 1'b0;
      end
      D_FLUSH: begin
        busy_s       = 1'b1;
        drain_done_s = fifo_empty_s && !cap_s;
      end
      default: begin
        busy_s       = 1'b0;
        drain_done_s = 1'b0;
      end
    endcase
  end

  assign busy       = busy_s;
  assign drain_done = drain_done_s;
  assign overflow   = overflow_r;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench: two drain instances (FIFO depth 4 and 2) share controller
// stimulus; expected rows/indices are computed by the bench.
module tb_systolic_result_drain;
  import simax_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int ACC_W = 32;
  localparam int CYC_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         gs;
  logic [CYC_W-1:0]   cyc;
  logic [COLS*ACC_W-1:0] acc;
  logic busy4, done4, ovf4, busy2, done2, ovf2;

  int n_vec = 0;
  int n_err = 0;

  systolic_result_drain_if #(.COLS(COLS), .ACC_W(ACC_W), .ROWS(ROWS)) if4 ();
  systolic_result_drain_if #(.COLS(COLS), .ACC_W(ACC_W), .ROWS(ROWS)) if2 ();

  systolic_result_drain #(.ROWS(ROWS), .COLS(COLS), .CYCLE_W(CYC_W), .ACC_W(ACC_W), .FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .global_state(gs), .cycle(cyc), .acc_row_in(acc),
    .res(if4.master), .busy(busy4), .drain_done(done4), .overflow(ovf4));

  systolic_result_drain #(.ROWS(ROWS), .COLS(COLS), .CYCLE_W(CYC_W), .ACC_W(ACC_W), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .global_state(gs), .cycle(cyc), .acc_row_in(acc),
    .res(if2.master), .busy(busy2), .drain_done(done2), .overflow(ovf2));

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_row(input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      v[c*32 +: 32] = 32'h10 + 32'(r) + 32'(c) * 32'h100;
    end
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] gs_v, input int c, input int r);
    gs  = gs_v;
    cyc = CYC_W'(c);
    acc = mk_row(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    if4.out_ready = v;
    if2.out_ready = v;
  endtask

  task automatic run_nominal(input string p);
    set_ready(1'b1);
    drive(S_LOAD_X, 0, 0); step();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(S_STORE, k, k);
      else       drive(S_IDLE, 0, 0);
      samp();
      if (k == 0) begin
        check_val({p, "_valid0"}, 128'(if4.out_valid), 128'd0);
        check_val({p, "_busy0"}, 128'(busy4), 128'd0);
      end else if (k <= 4) begin
        check_val($sformatf("%s_valid%0d", p, k), 128'(if4.out_valid), 128'd1);
        check_val($sformatf("%s_idx%0d", p, k), 128'(if4.out_row_idx), 128'(k - 1));
        check_val($sformatf("%s_data%0d", p, k), if4.out_data, mk_row(k - 1));
        check_val($sformatf("%s_last%0d", p, k), 128'(if4.out_last), 128'(k == 4));
        check_val($sformatf("%s_busy%0d", p, k), 128'(busy4), 128'd1);
        check_val($sformatf("%s_done%0d", p, k), 128'(done4), 128'd0);
        check_val($sformatf("%s_idx2_%0d", p, k), 128'(if2.out_row_idx), 128'(k - 1));
      end else begin
        check_val({p, "_empty"}, 128'(if4.out_valid), 128'd0);
        check_val({p, "_done4"}, 128'(done4), 128'd1);
        check_val({p, "_done2"}, 128'(done2), 128'd1);
      end
      step();
    end
    samp();
    check_val({p, "_busy_end"}, 128'(busy4), 128'd0);
    check_val({p, "_done_end"}, 128'(done4), 128'd0);
    check_val({p, "_ovf4"}, 128'(ovf4), 128'd0);
    check_val({p, "_ovf2"}, 128'(ovf2), 128'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(S_IDLE, 0, 0);
    set_ready(1'b1);
    step(); step();
    rst_n = 1'b1;
    samp();
    check_val("rst_valid", 128'(if4.out_valid), 128'd0);
    check_val("rst_last", 128'(if4.out_last), 128'd0);
    check_val("rst_busy", 128'(busy4), 128'd0);
    check_val("rst_done", 128'(done4), 128'd0);
    check_val("rst_ovf", 128'(ovf4), 128'd0);
    check_val("rst_data", if4.out_data, 128'd0);
    check_val("rst_idx", 128'(if4.out_row_idx), 128'd0);
    step();

    run_nominal("nom");

    // Backpressure on depth 4 (fills, no drop); depth 2 drops rows 2,3.
    drive(S_LOAD_X, 0, 0); step();
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(S_STORE, k, k); step();
    end
    drive(S_IDLE, 0, 0);
    for (int h = 0; h < 2; h++) begin
      samp();
      check_val($sformatf("bp_valid%0d", h), 128'(if4.out_valid), 128'd1);
      check_val($sformatf("bp_idx%0d", h), 128'(if4.out_row_idx), 128'd0);
      check_val($sformatf("bp_data%0d", h), if4.out_data, mk_row(0));
      check_val($sformatf("bp_done%0d", h), 128'(done4), 128'd0);
      check_val($sformatf("bp_busy%0d", h), 128'(busy4), 128'd1);
      check_val($sformatf("bp_ovf4_%0d", h), 128'(ovf4), 128'd0);
      check_val($sformatf("ov_ovf2_%0d", h), 128'(ovf2), 128'd1);
      check_val($sformatf("ov_idx2_%0d", h), 128'(if2.out_row_idx), 128'd0);
      step();
    end
    set_ready(1'b1);
    for (int j = 0; j < 5; j++) begin
      samp();
      if (j < 4) begin
        check_val($sformatf("bp_pop_idx%0d", j), 128'(if4.out_row_idx), 128'(j));
        check_val($sformatf("bp_pop_data%0d", j), if4.out_data, mk_row(j));
        check_val($sformatf("bp_pop_last%0d", j), 128'(if4.out_last), 128'(j == 3));
      end else begin
        check_val("bp_done", 128'(done4), 128'd1);
        check_val("bp_empty", 128'(if4.out_valid), 128'd0);
      end
      if (j < 2) begin
        check_val($sformatf("ov_pop_idx%0d", j), 128'(if2.out_row_idx), 128'(j));
        check_val($sformatf("ov_pop_data%0d", j), if2.out_data, mk_row(j));
        check_val($sformatf("ov_pop_last%0d", j), 128'(if2.out_last), 128'd0);
      end else if (j == 2) begin
        check_val("ov_done", 128'(done2), 128'd1);
        check_val("ov_empty", 128'(if2.out_valid), 128'd0);
      end
      step();
    end
    drive(S_LOAD_X, 0, 0); step();
    samp();
    check_val("ov_clear", 128'(ovf2), 128'd0);
    drive(S_IDLE, 0, 0); step();

    // Depth 2 full, then push and pop in the same cycle: nothing dropped.
    drive(S_LOAD_X, 0, 0); step();
    set_ready(1'b0);
    drive(S_STORE, 0, 0); step();
    drive(S_STORE, 1, 1); step();
    set_ready(1'b1);
    drive(S_STORE, 2, 2); samp();
    check_val("pp_idx_a", 128'(if2.out_row_idx), 128'd0);
    check_val("pp_ovf_a", 128'(ovf2), 128'd0);
    step();
    drive(S_STORE, 3, 3); samp();
    check_val("pp_idx_b", 128'(if2.out_row_idx), 128'd1);
    check_val("pp_data_b", if2.out_data, mk_row(1));
    check_val("pp_ovf_b", 128'(ovf2), 128'd0);
    step();
    drive(S_IDLE, 0, 0); samp();
    check_val("pp_idx_c", 128'(if2.out_row_idx), 128'd2);
    check_val("pp_data_c", if2.out_data, mk_row(2));
    check_val("pp_ovf_c", 128'(ovf2), 128'd0);
    step();
    samp();
    check_val("pp_idx_d", 128'(if2.out_row_idx), 128'd3);
    check_val("pp_last_d", 128'(if2.out_last), 128'd1);
    step();
    samp();
    check_val("pp_done", 128'(done2), 128'd1);
    check_val("pp_empty", 128'(if2.out_valid), 128'd0);
    step();

    // Short pass: two rows, then back to S_IDLE.
    drive(S_LOAD_X, 0, 0); step();
    drive(S_STORE, 0, 0); samp();
    check_val("sp_valid0", 128'(if4.out_valid), 128'd0);
    step();
    drive(S_STORE, 1, 1); samp();
    check_val("sp_idx0", 128'(if4.out_row_idx), 128'd0);
    check_val("sp_last0", 128'(if4.out_last), 128'd0);
    step();
    drive(S_IDLE, 0, 0); samp();
    check_val("sp_idx1", 128'(if4.out_row_idx), 128'd1);
    check_val("sp_last1", 128'(if4.out_last), 128'd0);
    check_val("sp_done_early", 128'(done4), 128'd0);
    step();
    samp();
    check_val("sp_done", 128'(done4), 128'd1);
    check_val("sp_empty", 128'(if4.out_valid), 128'd0);
    step();
    samp();
    check_val("sp_busy", 128'(busy4), 128'd0);
    step();

    // Reset with two rows buffered, then a full nominal pass.
    drive(S_LOAD_X, 0, 0); step();
    set_ready(1'b0);
    drive(S_STORE, 0, 0); step();
    drive(S_STORE, 1, 1); step();
    drive(S_IDLE, 0, 0); samp();
    check_val("mr_valid_pre", 128'(if4.out_valid), 128'd1);
    check_val("mr_busy_pre", 128'(busy4), 128'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    samp();
    check_val("mr_valid", 128'(if4.out_valid), 128'd0);
    check_val("mr_busy", 128'(busy4), 128'd0);
    check_val("mr_data", if4.out_data, 128'd0);
    check_val("mr_valid2", 128'(if2.out_valid), 128'd0);
    step();
    run_nominal("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
